segmax_row_controller: RTL and testbench
========================================

// Module: segmax_row_controller
// PURPOSE
//  Sequences the segmented max-reduction datapath for the softmax front end.
//  - Accepts one row configuration, then streams the row's score beats (8 signed lanes each).
//  - Keeps a running maximum per segment across all beats of the row.
//  - Returns the per-segment row maxima over a valid/ready handshake.
//  - Sits between the score buffer read port and the softmax exp/subtract stage.
// PARAMETERS
//  DATA_W  32  signed lane width
//  LANES   8   lanes per beat; fixed by the segment tree, not to be overridden
//  BEAT_W  8   width of the row beat count (max 255 beats per row)
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous, active-high reset
//  cfg_valid  in   1               row configuration offered
//  cfg_ready  out  1               high only in IDLE
//  cfg_mode   in   2               0=SEG2 (1 seg of 8 lanes), 1=SEG4 (2 segs of 4), 2=SEG8 (4 segs of 2), 3=illegal
//  cfg_beats  in   BEAT_W          beats in the row, must be 1..255
//  cfg_err    out  1               1-cycle pulse when a config is rejected
//  in_valid   in   1               score beat offered
//  in_ready   out  1               high only in ACCUM
//  in_data    in   LANES*DATA_W    lane i at [i*DATA_W +: DATA_W], signed
//  out_valid  out  1               row result held until accepted
//  out_ready  in   1               consumer accepts result
//  out_max    out  4*DATA_W        segment s max at [s*DATA_W +: DATA_W]; unused segments 0
//  out_mask   out  4               valid segments: SEG2=0001, SEG4=0011, SEG8=1111
//  busy       out  1               state != IDLE
// BEHAVIOUR
//  Reset
//   - Enter IDLE.
//   - cfg_ready=1; in_ready, out_valid, cfg_err, busy = 0.
//   - out_max, out_mask, beat counter and running-max registers = 0.
//  FSM
//   - IDLE -> ACCUM on cfg_valid&cfg_ready with mode<=2 and beats!=0:
//     - latch mode and beats;
//     - load all 4 running maxima with INT_MIN (32'h8000_0000);
//     - clear the beat counter.
//   - IDLE, rejected config (mode==3 or beats==0):
//     - config is consumed; cfg_err pulses next cycle; state stays IDLE.
//   - ACCUM, on each in_valid&in_ready:
//     - seg tree computes per-segment beat maxima (signed >, combinational);
//     - run_max[s] <= max(run_max[s], beat_max[s]); counter++.
//   - ACCUM -> OUT on acceptance of beat cfg_beats-1:
//     - the last beat is folded into the same registers;
//     - out_valid rises the next cycle (1-cycle latency from last beat).
//   - OUT: out_max and out_mask are stable while out_valid=1 and out_ready=0.
//   - OUT -> IDLE on out_valid&out_ready; cfg_ready is high the following cycle.
//     - No overlap between rows: a new config is only taken in IDLE.
//  Arithmetic
//   - All comparisons are signed DATA_W.
//   - Ties yield the equal value; lane identity is not reported.
//  Boundary conditions
//   - beats==1: OUT is entered after a single beat.
//   - beats==255: counter width suffices and there is no wrap.
//   - in_valid gaps in ACCUM stall without change.
//   - in_data outside ACCUM is ignored.
//   - rst mid-row or mid-OUT: partial state is discarded; no out_valid is produced.
//   - Throughput: 1 beat/cycle in ACCUM; overhead per row is 1 config cycle plus >=1 OUT cycle.
// STRUCTURE
//  - Package star_max_pkg:
//    - typedef enum logic[1:0] {MODE_SEG2, MODE_SEG4, MODE_SEG8} max_mode_e;
//    - localparam INT_MIN;
//    - typedef enum for the FSM {IDLE, ACCUM, OUT}.
//  - Sub-module max_seg_tree (combinational): in_data + mode -> 4 beat maxima.
//    - SEG2: full 8-lane tree into segment 0.
//    - SEG4: lanes 0-3 and 4-7.
//    - SEG8: pairs (0,1), (2,3), (4,5), (6,7).
//  - Controller holds the FSM, beat counter, run_max regs and handshakes.
// TESTING
//  1. SEG2, beats=2:
//     - beat0 lanes {-5,3,7,-1,0,2,6,1}; beat1 all -100;
//     - expect out_max[0]=7, mask=0001, out_max[3:1]=0.
//  2. SEG8, beats=3, all negatives:
//     - lane values -(beat*8+lane+1);
//     - expect segs {-1,-3,-5,-7}, mask=1111.
//  3. SEG4, beats=1, out_ready held low 5 cycles:
//     - lanes {1,9,2,8, -4,-2,-3,-9};
//     - out stays {9,-2}, mask=0011, until accept; cfg_ready returns next cycle.
//  4. Illegal config:
//     - cfg_mode=3 -> cfg_err pulse, stays IDLE;
//     - cfg_beats=0 -> cfg_err pulse;
//     - in_valid beats ignored; no out_valid.
//  5. rst asserted after 2 of 4 beats (SEG8):
//     - all outputs reach reset values next cycle;
//     - a new row of INT_MIN/INT_MAX lanes gives maxima 32'h7FFF_FFFF.
//  6. Back-to-back rows with random in_valid gaps (1000 rows):
//     - results match a scoreboard signed-max model.

Source files
------------

// File: rtl/segmax_row_controller_pkg.sv
// Shared types for the segmented row-max controller and its lane tree.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package star_max_pkg;

  // Segment layouts. Encoding 2'd3 is deliberately left out and is rejected at config time.
  typedef enum logic [1:0] {
    MODE_SEG2 = 2'd0,  // one segment of 8 lanes
    MODE_SEG4 = 2'd1,  // two segments of 4 lanes
    MODE_SEG8 = 2'd2   // four segments of 2 lanes
  } max_mode_e;

  // Most negative 32-bit signed value. Seeds every running max so the first beat always wins.
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } row_state_e;

  // One bit per result segment that carries a meaningful maximum.
  function automatic logic [3:0] mode_mask(input max_mode_e m);
    case (m)
      MODE_SEG2: return 4'b0001;
      MODE_SEG4: return 4'b0011;
      MODE_SEG8: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/segmax_row_controller_seg_tree.sv
// Purpose: combinational per-segment maximum of one 8-lane signed beat.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the inputs.
// Ports:
//   i_data      8 signed lanes, lane i at [i*DATA_W +: DATA_W]
//   i_mode      segment layout
//   o_beat_max  segment s max at [s*DATA_W +: DATA_W]; unused segments carry the most negative value
module max_seg_tree
  import star_max_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 8
) (
  input  logic [LANES*DATA_W-1:0] i_data,
  input  max_mode_e               i_mode,
  output logic [4*DATA_W-1:0]     o_beat_max
);

  localparam logic [DATA_W-1:0] LANE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [DATA_W-1:0] w_lane [8];
  logic [DATA_W-1:0] w_pair [4];
  logic [DATA_W-1:0] w_quad [2];
  logic [DATA_W-1:0] w_full;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign w_lane[i] = i_data[i*DATA_W +: DATA_W];
  end

  // A single reduction tree serves all three layouts: the pair level is the SEG8 result,
  // the quad level is SEG4, and the root is SEG2.
  for (genvar p = 0; p < 4; p++) begin : g_pair
    assign w_pair[p] = smax(w_lane[2*p], w_lane[2*p+1]);
  end
  assign w_quad[0] = smax(w_pair[0], w_pair[1]);
  assign w_quad[1] = smax(w_pair[2], w_pair[3]);
  assign w_full    = smax(w_quad[0], w_quad[1]);

  // Unused segments are driven with the most negative value so folding them is a no-op.
  always_comb begin
    o_beat_max = {4{LANE_MIN}};
    case (i_mode)
      MODE_SEG4: o_beat_max = {LANE_MIN, LANE_MIN, w_quad[1], w_quad[0]};
      MODE_SEG8: o_beat_max = {w_pair[3], w_pair[2], w_pair[1], w_pair[0]};
      default:   o_beat_max = {LANE_MIN, LANE_MIN, LANE_MIN, w_full};
    endcase
  end

endmodule

// File: rtl/segmax_row_controller.sv
// Purpose: takes a row config, folds the row's score beats into per-segment running maxima, returns the result.
// Latency: out_valid rises 1 cycle after the last beat is accepted. One beat per cycle is folded in ACCUM.
// Backpressure: in_ready is high only in ACCUM. The result is held stable until out_ready. Configs are taken only in IDLE.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_mode/cfg_beats/cfg_err   row configuration handshake and reject pulse
//   in_valid/in_ready/in_data         score beat stream (8 signed lanes)
//   out_valid/out_ready/out_max/out_mask             per-segment row maxima and segment mask
//   busy                              high while a row is in flight
module segmax_row_controller
  import star_max_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int BEAT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_mode,
  input  logic [BEAT_W-1:0]       cfg_beats,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DATA_W-1:0]     out_max,
  output logic [3:0]              out_mask,
  output logic                    busy
);

  localparam logic [DATA_W-1:0] LANE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  row_state_e           r_state;
  max_mode_e            r_mode;
  logic [BEAT_W-1:0]    r_beats;
  logic [BEAT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]    r_run_max [4];
  logic                 r_cfg_ready;
  logic                 r_cfg_err;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [4*DATA_W-1:0]  r_out_max;
  logic [3:0]           r_out_mask;

  logic [4*DATA_W-1:0]  w_beat_max;
  logic [DATA_W-1:0]    w_fold [4];
  logic [3:0]           w_mask;
  logic                 w_cfg_ok;
  logic                 w_last_beat;

  max_seg_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_tree (
    .i_data     (in_data),
    .i_mode     (r_mode),
    .o_beat_max (w_beat_max)
  );

  for (genvar s = 0; s < 4; s++) begin : g_fold
    assign w_fold[s] = ($signed(w_beat_max[s*DATA_W +: DATA_W]) > $signed(r_run_max[s]))
                       ? w_beat_max[s*DATA_W +: DATA_W] : r_run_max[s];
  end

  assign w_mask      = mode_mask(r_mode);
  assign w_cfg_ok    = (cfg_mode != 2'd3) && (cfg_beats != '0);
  // Counter holds the number of beats already folded, so the last beat is the one seen at beats-1.
  assign w_last_beat = (r_cnt == r_beats - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= MODE_SEG2;
      r_beats     <= '0;
      r_cnt       <= '0;
      for (int s = 0; s < 4; s++) r_run_max[s] <= '0;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_max   <= '0;
      r_out_mask  <= '0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_valid && r_cfg_ready) begin
            if (w_cfg_ok) begin
              r_state     <= ACCUM;
              r_mode      <= max_mode_e'(cfg_mode);
              r_beats     <= cfg_beats;
              r_cnt       <= '0;
              for (int s = 0; s < 4; s++) r_run_max[s] <= LANE_MIN;
              r_cfg_ready <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              // Rejected config is consumed; the controller stays ready for the next one.
              r_cfg_err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid && r_in_ready) begin
            for (int s = 0; s < 4; s++) r_run_max[s] <= w_fold[s];
            r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
              // Result is taken from the folded values so the last beat is included.
              r_state     <= OUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_mask  <= w_mask;
              for (int s = 0; s < 4; s++)
                r_out_max[s*DATA_W +: DATA_W] <= w_mask[s] ? w_fold[s] : '0;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign cfg_err   = r_cfg_err;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_max   = r_out_max;
  assign out_mask  = r_out_mask;
  assign busy      = r_busy;

endmodule

// File: tb/tb_segmax_row_controller.sv
// Directed and randomized-row bench for the segmented row-max controller.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Backpressure is exercised by holding out_ready low and by gapping in_valid.
module tb_segmax_row_controller;
  import star_max_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_mode = 2'd0;
  logic [7:0]   cfg_beats = 8'd0;
  logic         cfg_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_max;
  logic [3:0]   out_mask;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  segmax_row_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_beats (cfg_beats),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_mask  (out_mask),
    .busy      (busy)
  );

  function automatic logic [255:0] pack8(input logic [31:0] a [8]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [1:0] mode, input logic [7:0] beats);
    int n;
    n = 0;
    while (!cfg_ready && n < 100) begin step(); n++; end
    if (!cfg_ready) begin
      total++; bad++;
      $display("FAIL cfg_ready_wait got=%0b want=1", cfg_ready);
    end
    cfg_mode = mode; cfg_beats = beats; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [255:0] data, input int gap);
    int n;
    repeat (gap) step();
    in_data = data; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_wait got=%0b want=1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic accept(input int delay);
    repeat (delay) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({cfg_ready, in_ready, out_valid, cfg_err, busy} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=10000", {cfg_ready, in_ready, out_valid, cfg_err, busy});
    end
    total++;
    if (out_max !== 128'd0 || out_mask !== 4'd0) begin
      bad++;
      $display("FAIL reset_out got=%h/%b want=0/0000", out_max, out_mask);
    end
  endtask

  task automatic test_seg2();
    logic [31:0] l [8];
    l = '{-5, 3, 7, -1, 0, 2, 6, 1};
    send_cfg(2'd0, 8'd2);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL seg2_accum busy=%b in_ready=%b cfg_ready=%b want 1 1 0", busy, in_ready, cfg_ready);
    end
    send_beat(pack8(l), 0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL seg2_early_valid got=%b want=0", out_valid); end
    for (int i = 0; i < 8; i++) l[i] = -100;
    send_beat(pack8(l), 0);
    total++;
    if (out_valid !== 1'b1 || out_max !== {96'd0, 32'd7} || out_mask !== 4'b0001) begin
      bad++;
      $display("FAIL seg2_result valid=%b max=%h mask=%b want 1 %h 0001", out_valid, out_max, out_mask, {96'd0, 32'd7});
    end
    accept(0);
    total++;
    if (out_valid !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL seg2_release valid=%b cfg_ready=%b busy=%b want 0 1 0", out_valid, cfg_ready, busy);
    end
  endtask

  task automatic test_seg8_neg();
    logic [31:0]  l [8];
    logic [127:0] exp_max;
    exp_max = {32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    send_cfg(2'd2, 8'd3);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) l[i] = -(b*8 + i + 1);
      send_beat(pack8(l), b);
    end
    total++;
    if (out_valid !== 1'b1 || out_max !== exp_max || out_mask !== 4'b1111) begin
      bad++;
      $display("FAIL seg8_neg valid=%b max=%h mask=%b want 1 %h 1111", out_valid, out_max, out_mask, exp_max);
    end
    accept(1);
  endtask

  task automatic test_hold();
    logic [31:0]  l [8];
    logic [127:0] exp_max;
    l = '{1, 9, 2, 8, -4, -2, -3, -9};
    exp_max = {64'd0, 32'hFFFF_FFFE, 32'd9};
    send_cfg(2'd1, 8'd1);
    send_beat(pack8(l), 0);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_max !== exp_max || out_mask !== 4'b0011 || cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_c%0d valid=%b max=%h mask=%b cfg_ready=%b want 1 %h 0011 0",
                 c, out_valid, out_max, out_mask, cfg_ready, exp_max);
      end
      l[0] = 32'd1000;  // input changes while waiting must not leak into the held result
      in_data = pack8(l);
      step();
    end
    accept(0);
    total++;
    if (cfg_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release cfg_ready=%b valid=%b want 1 0", cfg_ready, out_valid);
    end
  endtask

  task automatic test_illegal();
    send_cfg(2'd3, 8'd4);
    total++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal_mode err=%b cfg_ready=%b busy=%b want 1 1 0", cfg_err, cfg_ready, busy);
    end
    step();
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL illegal_pulse_width got=%b want=0", cfg_err); end
    send_cfg(2'd1, 8'd0);
    total++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal_beats err=%b busy=%b want 1 0", cfg_err, busy);
    end
    in_data = {8{32'h7FFF_0000}};
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore_c%0d in_ready=%b valid=%b busy=%b want 0 0 0", c, in_ready, out_valid, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [31:0] l [8];
    send_cfg(2'd2, 8'd4);
    for (int i = 0; i < 8; i++) l[i] = i * 3;
    send_beat(pack8(l), 0);
    send_beat(pack8(l), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({cfg_ready, in_ready, out_valid, cfg_err, busy} !== 5'b10000 || out_max !== 128'd0 || out_mask !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid flags=%b max=%h mask=%b want 10000 0 0000",
               {cfg_ready, in_ready, out_valid, cfg_err, busy}, out_max, out_mask);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_novalid_c%0d got=%b want=0", c, out_valid); end
    end
    for (int i = 0; i < 8; i++) l[i] = (i % 2 == 0) ? INT_MIN : 32'h7FFF_FFFF;
    send_cfg(2'd2, 8'd1);
    send_beat(pack8(l), 0);
    total++;
    if (out_valid !== 1'b1 || out_max !== {4{32'h7FFF_FFFF}} || out_mask !== 4'b1111) begin
      bad++;
      $display("FAIL rst_new_row valid=%b max=%h mask=%b want 1 %h 1111",
               out_valid, out_max, out_mask, {4{32'h7FFF_FFFF}});
    end
    accept(0);
  endtask

  task automatic test_max_beats();
    logic [31:0] l [8];
    send_cfg(2'd1, 8'd255);
    for (int k = 0; k < 255; k++) begin
      for (int i = 0; i < 4; i++) l[i] = k - 128;
      for (int i = 4; i < 8; i++) l[i] = -k;
      send_beat(pack8(l), 0);
      if (k == 253) begin
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL beats255_early valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
      end
    end
    total++;
    if (out_valid !== 1'b1 || out_max !== {64'd0, 32'd0, 32'd126} || out_mask !== 4'b0011) begin
      bad++;
      $display("FAIL beats255_result valid=%b max=%h mask=%b want 1 %h 0011",
               out_valid, out_max, out_mask, {64'd0, 32'd0, 32'd126});
    end
    accept(0);
  endtask

  task automatic test_back_to_back();
    logic [31:0]        l [8];
    logic signed [31:0] em [4];
    logic [127:0]       exp_max;
    logic [3:0]         exp_mask;
    int mode, beats, seg, nseg, n;
    for (int r = 0; r < 1000; r++) begin
      mode  = $urandom_range(0, 2);
      beats = $urandom_range(1, 4);
      for (int s = 0; s < 4; s++) em[s] = INT_MIN;
      send_cfg(mode[1:0], beats[7:0]);
      for (int b = 0; b < beats; b++) begin
        for (int i = 0; i < 8; i++) begin
          // Small-range values make ties frequent.
          l[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          seg  = (mode == 0) ? 0 : (mode == 1) ? i / 4 : i / 2;
          if ($signed(l[i]) > em[seg]) em[seg] = l[i];
        end
        send_beat(pack8(l), $urandom_range(0, 2));
      end
      nseg = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
      exp_max = '0; exp_mask = '0;
      for (int s = 0; s < nseg; s++) begin
        exp_max[s*32 +: 32] = em[s];
        exp_mask[s] = 1'b1;
      end
      n = 0;
      while (!out_valid && n < 100) begin step(); n++; end
      total++;
      if (out_valid !== 1'b1 || out_max !== exp_max || out_mask !== exp_mask) begin
        bad++;
        $display("FAIL b2b_row%0d valid=%b max=%h mask=%b want 1 %h %b",
                 r, out_valid, out_max, out_mask, exp_max, exp_mask);
      end
      accept($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_seg2();
    test_seg8_neg();
    test_hold();
    test_illegal();
    test_rst_mid();
    test_max_beats();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
